// File: rtl/aes_sbox_out_stage.sv
// Masked AES S-box output stage: back basis change, enc/dec select,
// affine constant on share 0 and a 2-entry registered FIFO.
module aes_sbox_out_stage #(
  parameter int NUM_SHARES = 2,
  parameter int NUM_BYTES  = 4
) (
  input  logic                            in_clock,
  input  logic                            in_reset,
  input  logic [NUM_SHARES*NUM_BYTES*8-1:0] in_shares,
  input  logic                            in_decrypt,
  input  logic                            in_valid,
  output logic                            out_ready,
  output logic [NUM_SHARES*NUM_BYTES*8-1:0] out_shares,
  output logic                            out_decrypt,
  output logic                            out_valid,
  input  logic                            in_ready,
  output logic [1:0]                      out_level
);

  localparam int W = NUM_SHARES * NUM_BYTES * 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Tower basis -> polynomial basis, merged with the affine matrix.
  function automatic logic [7:0] fwd_map(input logic [7:0] x);
    logic [7:0] y;
    y[7] = x[5] ^ x[3];
    y[6] = x[7] ^ x[3];
    y[5] = x[6] ^ x[0];
    y[4] = x[7] ^ x[5] ^ x[3];
    y[3] = x[7] ^ x[6] ^ x[5] ^ x[4] ^ x[3];
    y[2] = x[6] ^ x[5] ^ x[3] ^ x[2] ^ x[0];
    y[1] = x[5] ^ x[4] ^ x[1];
    y[0] = x[6] ^ x[4] ^ x[1];
    return y;
  endfunction

  // Tower basis -> polynomial basis only (inverse S-box result).
  function automatic logic [7:0] bwd_map(input logic [7:0] x);
    logic [7:0] y;
    y[7] = x[4] ^ x[1];
    y[6] = x[7] ^ x[6] ^ x[5] ^ x[3] ^ x[1] ^ x[0];
    y[5] = x[7] ^ x[6] ^ x[5] ^ x[3] ^ x[2] ^ x[0];
    y[4] = x[6] ^ x[1];
    y[3] = x[6] ^ x[5] ^ x[4] ^ x[3] ^ x[2] ^ x[1];
    y[2] = x[7] ^ x[5] ^ x[4] ^ x[1];
    y[1] = x[5] ^ x[1];
    y[0] = x[2];
    return y;
  endfunction

  logic [W-1:0] sbox_d;

  for (genvar s = 0; s < NUM_SHARES; s++) begin : g_share
    for (genvar b = 0; b < NUM_BYTES; b++) begin : g_lane
      localparam int LSB = (s * NUM_BYTES + b) * 8;
      localparam logic [7:0] AFF = (s == 0) ? 8'h63 : 8'h00;
      logic [7:0] x;
      assign x = in_shares[LSB +: 8];
      assign sbox_d[LSB +: 8] = in_decrypt ? bwd_map(x)
                                           : (fwd_map(x) ^ AFF);
    end
  end

  state_t       state_q;
  logic         head_q;
  logic         tail_q;
  logic [W:0]   ent_q [2];
  logic         push;
  logic         pop;

  assign out_ready = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign push      = in_valid & out_ready;
  assign pop       = out_valid & in_ready;
  assign out_level = state_q;

  // Outputs come only from the head register, never from the input.
  assign {out_decrypt, out_shares} = ent_q[head_q];

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      state_q  <= EMPTY;
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
      ent_q[0] <= '0;
      ent_q[1] <= '0;
    end else begin
      if (push) begin
        ent_q[tail_q] <= {in_decrypt, sbox_d};
        tail_q        <= ~tail_q;
      end
      if (pop) begin
        head_q <= ~head_q;
      end
      unique case (state_q)
        EMPTY: begin
          if (push) state_q <= ONE;
        end
        ONE: begin
          if (push & ~pop)      state_q <= FULL;
          else if (pop & ~push) state_q <= EMPTY;
        end
        FULL: begin
          if (pop) state_q <= ONE;
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_sbox_out_stage.sv
// Randomized bench for aes_sbox_out_stage against a GF(2^8)
// reference S-box and a queue model of the output FIFO.
module tb_aes_sbox_out_stage;

  localparam int NS = 2;
  localparam int NB = 4;
  localparam int W  = NS * NB * 8;

  logic           clk = 1'b0;
  logic           in_reset;
  logic [W-1:0]   in_shares;
  logic           in_decrypt;
  logic           in_valid;
  logic           out_ready;
  logic [W-1:0]   out_shares;
  logic           out_decrypt;
  logic           out_valid;
  logic           in_ready;
  logic [1:0]     out_level;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit rnd_bp = 1'b0;

  logic [7:0] ginv_t  [256];
  logic [7:0] sbox_t  [256];
  logic [7:0] isbox_t [256];
  logic [7:0] tinv_t  [256];
  logic [31:0] pend_gold;

  // Polynomial-basis image of each tower-basis bit.
  localparam logic [7:0] X2A [8] = '{8'h60, 8'hde, 8'h29, 8'h68,
                                     8'h8c, 8'h6e, 8'h78, 8'h64};

  typedef struct packed {
    logic        dec;
    logic [W-1:0] sh;
    logic [31:0] gold;
  } exp_t;

  exp_t q[$];

  aes_sbox_out_stage #(.NUM_SHARES(NS), .NUM_BYTES(NB)) dut (
    .in_clock   (clk),
    .in_reset   (in_reset),
    .in_shares  (in_shares),
    .in_decrypt (in_decrypt),
    .in_valid   (in_valid),
    .out_ready  (out_ready),
    .out_shares (out_shares),
    .out_decrypt(out_decrypt),
    .out_valid  (out_valid),
    .in_ready   (in_ready),
    .out_level  (out_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rnd_bp) begin
      #1;
      in_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p  = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] aff_lin(input logic [7:0] x);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]}
             ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]};
  endfunction

  function automatic logic [7:0] tmap(input logic [7:0] x);
    logic [7:0] r = 8'h00;
    for (int j = 0; j < 8; j++)
      if (x[j]) r = r ^ X2A[j];
    return r;
  endfunction

  function automatic logic [W-1:0] model_sh(input logic dec,
                                            input logic [W-1:0] sh);
    logic [W-1:0] r = '0;
    logic [7:0] v;
    for (int s = 0; s < NS; s++)
      for (int b = 0; b < NB; b++) begin
        v = tmap(sh[(s*NB+b)*8 +: 8]);
        if (!dec) v = aff_lin(v) ^ ((s == 0) ? 8'h63 : 8'h00);
        r[(s*NB+b)*8 +: 8] = v;
      end
    return r;
  endfunction

  function automatic logic [31:0] recomb(input logic [W-1:0] sh);
    logic [31:0] r = '0;
    for (int b = 0; b < NB; b++)
      for (int s = 0; s < NS; s++)
        r[b*8 +: 8] = r[b*8 +: 8] ^ sh[(s*NB+b)*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] gold_of(input logic dec,
                                          input logic [W-1:0] sh);
    logic [31:0] xr = recomb(sh);
    logic [31:0] r  = '0;
    for (int b = 0; b < NB; b++)
      r[b*8 +: 8] = dec ? tmap(xr[b*8 +: 8])
                        : sbox_t[ginv_t[tmap(xr[b*8 +: 8])]];
    return r;
  endfunction

  // FIFO scoreboard: compares head, then applies this edge's pop/push.
  always @(negedge clk) begin
    bit do_pop;
    bit do_push;
    if (!in_reset) begin
      chk("valid", 64'(out_valid), 64'(q.size() != 0));
      chk("level", 64'(out_level), 64'(q.size()));
      chk("ready", 64'(out_ready), 64'(q.size() < 2));
      if (q.size() != 0) begin
        chk("shares", out_shares, q[0].sh);
        chk("decrypt", 64'(out_decrypt), 64'(q[0].dec));
        chk("recomb", 64'(recomb(out_shares)), 64'(q[0].gold));
      end
      do_pop  = (q.size() != 0) && in_ready;
      do_push = in_valid && (q.size() < 2);
      if (do_pop) void'(q.pop_front());
      if (do_push)
        q.push_back('{dec: in_decrypt,
                      sh: model_sh(in_decrypt, in_shares),
                      gold: pend_gold});
    end
  end

  task automatic send(input logic dec, input logic [W-1:0] sh,
                      input logic [31:0] gold);
    bit acc;
    in_decrypt = dec;
    in_shares  = sh;
    pend_gold  = gold;
    in_valid   = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      acc = out_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_rnd(input logic dec);
    logic [W-1:0] sh = {$urandom, $urandom};
    send(dec, sh, gold_of(dec, sh));
  endtask

  task automatic pop_one();
    in_ready = 1'b1;
    @(posedge clk);
    #1;
    in_ready = 1'b0;
  endtask

  task automatic drain();
    in_ready = 1'b1;
    for (int k = 0; k < 50 && q.size() != 0; k++) @(posedge clk);
    #1;
    chk("drain", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] sh;
    logic [31:0]  gd;
    logic [7:0]   x;
    logic [7:0]   m;
    int           c0;

    in_reset   = 1'b1;
    in_valid   = 1'b0;
    in_ready   = 1'b0;
    in_decrypt = 1'b0;
    in_shares  = '0;
    pend_gold  = '0;

    for (int a = 0; a < 256; a++) begin
      ginv_t[a] = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) ginv_t[a] = 8'(b);
    end
    for (int a = 0; a < 256; a++) begin
      sbox_t[a] = aff_lin(ginv_t[a]) ^ 8'h63;
      isbox_t[sbox_t[a]] = 8'(a);
      tinv_t[tmap(8'(a))] = 8'(a);
    end

    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ready", 64'(out_ready), 64'd1);
    chk("rst_level", 64'(out_level), 64'd0);
    chk("rst_shares", out_shares, 64'd0);
    chk("rst_decrypt", 64'(out_decrypt), 64'd0);
    @(posedge clk);
    #1;
    in_reset = 1'b0;

    // Directed vectors on lane 0
    sh = 64'h00000000_00000001;
    send(1'b0, sh, gold_of(1'b0, sh));
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_shares", out_shares, 64'h00000000_63636347);
    pop_one();
    send(1'b1, sh, gold_of(1'b1, sh));
    chk("t2_shares", out_shares, 64'h00000000_00000060);
    chk("t2_decrypt", 64'(out_decrypt), 64'd1);
    pop_one();
    sh = 64'h00000001_00000000;
    send(1'b0, sh, gold_of(1'b0, sh));
    chk("t2_share1", out_shares, 64'h00000024_63636363);
    pop_one();

    // Backpressure: third transaction waits while full
    in_ready = 1'b0;
    send_rnd(1'b0);
    send_rnd(1'b1);
    fork
      send_rnd(1'b0);
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("t3_ready", 64'(out_ready), 64'd0);
        chk("t3_level", 64'(out_level), 64'd2);
        in_ready = 1'b1;
      end
    join
    drain();

    // Streaming push+pop in ONE
    in_ready = 1'b1;
    send_rnd(1'($urandom_range(0, 1)));
    c0 = cyc;
    for (int i = 0; i < 100; i++) send_rnd(1'($urandom_range(0, 1)));
    chk("t4_tput", 64'(cyc - c0), 64'd100);
    drain();

    // Asynchronous reset while full
    in_ready = 1'b0;
    send_rnd(1'b0);
    send_rnd(1'b1);
    @(posedge clk);
    #2;
    in_reset = 1'b1;
    #1;
    chk("t5_valid", 64'(out_valid), 64'd0);
    chk("t5_level", 64'(out_level), 64'd0);
    chk("t5_shares", out_shares, 64'd0);
    chk("t5_decrypt", 64'(out_decrypt), 64'd0);
    chk("t5_ready", 64'(out_ready), 64'd1);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    in_reset = 1'b0;
    in_ready = 1'b1;
    send_rnd(1'b0);
    drain();

    // Every byte value, both directions, random masks
    rnd_bp = 1'b1;
    for (int dir = 0; dir < 2; dir++)
      for (int g = 0; g < 64; g++) begin
        sh = '0;
        gd = '0;
        for (int b = 0; b < NB; b++) begin
          x = (dir == 0) ? tinv_t[ginv_t[g*NB+b]]
                         : tinv_t[isbox_t[g*NB+b]];
          m = 8'($urandom);
          sh[b*8 +: 8]      = x ^ m;
          sh[(NB+b)*8 +: 8] = m;
          gd[b*8 +: 8] = (dir == 0) ? sbox_t[g*NB+b]
                                    : isbox_t[g*NB+b];
        end
        send(1'(dir), sh, gd);
      end
    rnd_bp = 1'b0;
    @(posedge clk);
    #2;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
